// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared access-size codes and FSM state encodings for the memory responder
package mem_responder_pkg;

  // Access size codes, shared with the requester side
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  // Responder FSM state encodings
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

endpackage

// File: rtl/mem_byte_lanes.sv
// rtl/mem_byte_lanes.sv - byte-enable, write-lane shift, misalign detect and read extraction
module mem_byte_lanes
  import mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  output logic [31:0] rdata
);

  logic [31:0] rshift;

  // Decode size and low address bits into lane enables and justified data
  always_comb begin
    byte_en    = 4'b0000;
    misalign   = 1'b0;
    rdata      = 32'h0;
    rshift     = rword >> {addr_lo, 3'b000};
    wdata_lane = wdata << {addr_lo, 3'b000};
    case (ctrl)
      MEM_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        rdata   = {24'h0, rshift[7:0]};
      end
      MEM_HALF: begin
        misalign = addr_lo[0];
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata    = {16'h0, rshift[15:0]};
      end
      MEM_WORD: begin
        misalign = (addr_lo != 2'b00);
        byte_en  = 4'b1111;
        rdata    = rshift;
      end
      default: begin
        // Reserved size: the top level flags it as an error, no lanes enabled
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory target with programmable wait states, byte/half/word access and error reporting
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int RAM_SIZE  = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [1:0]           req_ctrl,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int         IDX_W  = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic                 r_write;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [1:0]           r_ctrl;

  logic                 acc_write;
  logic [WORD_SIZE-1:0] acc_addr;
  logic [WORD_SIZE-1:0] acc_wdata;
  logic [1:0]           acc_ctrl;
  logic [IDX_W-1:0]     acc_idx;
  logic                 out_of_range;
  logic                 acc_err;
  logic                 commit;
  logic [31:0]          ram_word;
  logic [3:0]           byte_en;
  logic [31:0]          wdata_lane;
  logic                 misalign;
  logic [31:0]          lane_rdata;

  logic [31:0] ram [RAM_SIZE];

  // With zero latency the access commits straight from the live request in IDLE;
  // otherwise it uses the request captured on accept.
  always_comb begin
    acc_write    = (state == S_IDLE) ? req_write : r_write;
    acc_addr     = (state == S_IDLE) ? req_addr  : r_addr;
    acc_wdata    = (state == S_IDLE) ? req_wdata : r_wdata;
    acc_ctrl     = (state == S_IDLE) ? req_ctrl  : r_ctrl;
    acc_idx      = acc_addr[IDX_W+1:2];
    out_of_range = ({2'b00, acc_addr[WORD_SIZE-1:2]} >= 32'(RAM_SIZE));
    acc_err      = out_of_range || misalign || (acc_ctrl == MEM_RSVD);
    ram_word     = out_of_range ? 32'h0 : ram[acc_idx];
    commit       = ((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state == S_WAIT) && (cnt == 4'd0));
  end

  mem_byte_lanes u_lanes (
    .addr_lo    (acc_addr[1:0]),
    .ctrl       (acc_ctrl),
    .wdata      (acc_wdata),
    .rword      (ram_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .misalign   (misalign),
    .rdata      (lane_rdata)
  );

  // Request/response FSM: accept, count wait states, commit, then hold the response.
  // After the response handshake the FSM spends one more cycle in RESP with
  // rsp_valid low so no new request is accepted in the completing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      if (commit) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_write) ? '0 : lane_rdata;
      end
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_ctrl    <= req_ctrl;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_valid) begin
            if (rsp_ready) rsp_valid <= 1'b0;
          end else begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // RAM byte-lane write on the commit edge; errors and reset suppress it
  always_ff @(posedge clk) begin
    if (commit && !rst && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a byte-array memory model
module tb_mem_responder;

  localparam int RAM_SIZE = 1024;
  localparam int LAT      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_ctrl;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_ctrl;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [4*RAM_SIZE];

  always #5 clk = ~clk;

  mem_responder #(.WORD_SIZE(32), .RAM_SIZE(RAM_SIZE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.WORD_SIZE(32), .RAM_SIZE(16), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ctrl(b_req_ctrl),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-addressed little-endian memory, access of 2**ctrl bytes
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] c, output logic [31:0] er, output logic ee);
    int n;
    n  = 1 << c;
    ee = (c == 2'b11) || (a % n != 0) || ((a / 4) >= RAM_SIZE);
    er = 32'h0;
    if (!ee) begin
      for (int i = 0; i < n; i++) begin
        if (w) mem[a + i] = wd[8*i +: 8];
        else   er = er | (32'(mem[a + i]) << (8 * i));
      end
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] c, input int hold, input string tag,
                      output logic [31:0] got);
    int n;
    logic [31:0] er;
    logic ee;
    req_write = w; req_addr = a; req_wdata = wd; req_ctrl = c; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_ctrl = 2'($urandom);
    model(w, a, wd, c, er, ee);
    n = 1;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
    chk({tag, "_rdata"}, rsp_rdata, er);
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    got = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, er);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(ee));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_no_accept"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got, er;
    logic ee;
    int acc[$];
    int val[$];

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_ctrl = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_ctrl = '0; b_rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    step();

    // Known contents for the low window
    for (int a = 0; a < 64; a += 4) xact(1'b1, 32'(a), $urandom, 2'b10, 0, "init", got);

    // Word store/load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 0, "t1_st", got);
    chk("t1_st_rdata0", got, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 0, "t1_ld", got);
    chk("t1_ld_const", got, 32'hDEADBEEF);

    // Byte/half lanes
    xact(1'b1, 32'h13, 32'h000000AA, 2'b00, 0, "t2_stb", got);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 0, "t2_ldw", got);
    chk("t2_ldw_const", got, 32'hAAADBEEF);
    xact(1'b0, 32'h12, 32'h0, 2'b01, 0, "t2_ldh", got);
    chk("t2_ldh_const", got, 32'h0000AAAD);
    xact(1'b0, 32'h11, 32'h0, 2'b00, 0, "t2_ldb", got);
    chk("t2_ldb_const", got, 32'h000000BE);

    // Errors
    xact(1'b0, 32'h12, 32'h0, 2'b10, 0, "t3_ldw_mis", got);
    xact(1'b1, 32'h11, 32'h0000FFFF, 2'b01, 0, "t3_sth_mis", got);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 0, "t3_unchanged", got);
    chk("t3_unchanged_const", got, 32'hAAADBEEF);
    xact(1'b0, 32'(4 * RAM_SIZE), 32'h0, 2'b10, 0, "t3_oor", got);
    xact(1'b0, 32'h14, 32'h0, 2'b11, 0, "t3_rsvd", got);

    // Backpressure
    xact(1'b0, 32'h10, 32'h0, 2'b10, 5, "t4_bp", got);

    // Reset while the store is waiting with its counter at zero
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_ctrl = 2'b10; req_valid = 1'b1;
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_req_ready", 32'(req_ready), 32'd1);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_rdata", rsp_rdata, 32'h0);
    chk("t6_rst_err", 32'(rsp_err), 32'd0);
    xact(1'b0, 32'h20, 32'h0, 2'b10, 0, "t6_ld", got);
    model(1'b0, 32'h20, 32'h0, 2'b10, er, ee);
    chk("t6_prior", got, er);

    // Random traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'(4 * RAM_SIZE) + 32'($urandom_range(0, 255))
                                      : 32'($urandom_range(0, 63));
      xact(1'($urandom), a, $urandom, 2'($urandom), $urandom_range(0, 2), "rnd", got);
    end

    // Zero-latency instance: back-to-back requests with response always accepted
    b_req_write = 1'b0; b_req_addr = 32'h0; b_req_ctrl = 2'b10;
    b_req_valid = 1'b1; b_rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (b_req_valid && b_req_ready) acc.push_back(c);
      if (b_rsp_valid) begin
        val.push_back(c);
        chk("t5_err", 32'(b_rsp_err), 32'd0);
      end
      step();
    end
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    chk("t5_accepts", 32'(acc.size()), 32'd6);
    chk("t5_valids", 32'(val.size()), 32'd5);
    for (int i = 0; i < acc.size(); i++) chk("t5_accept_cycle", 32'(acc[i]), 32'(3 * i));
    for (int i = 0; i < val.size() && i < acc.size(); i++) chk("t5_latency", 32'(val[i] - acc[i]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
